// File: rtl/apu_pkg.sv
// Shared APU definitions: register field layouts, address map, length and duty lookup tables.
package apu_pkg;

  localparam int unsigned VOL_BITS  = 4;
  localparam int unsigned LEN_IDX_W = 5;

  typedef logic [VOL_BITS-1:0] vol_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_SWEEP  = 2'd1;
  localparam logic [1:0] ADDR_TMR_LO = 2'd2;
  localparam logic [1:0] ADDR_TMR_HI = 2'd3;

  typedef struct packed {
    logic [1:0] duty;
    logic       halt;
    logic       cst;
    vol_t       v;
  } ctrl_reg_t;

  typedef struct packed {
    logic       en;
    logic [2:0] period;
    logic       neg;
    logic [2:0] shift;
  } sweep_reg_t;

  typedef struct packed {
    logic [LEN_IDX_W-1:0] len_idx;
    logic [2:0]           period_hi;
  } tmr_hi_reg_t;

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  // Bit n of each row is the waveform level at sequencer index n.
  localparam logic [7:0] DUTY_TABLE [4] = '{
    8'b0100_0000, 8'b0110_0000, 8'b0111_1000, 8'b1001_1111
  };

  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] seq);
    logic [7:0] row;
    row = DUTY_TABLE[duty];
    return row[seq];
  endfunction

endpackage

// File: rtl/apu_envelope.sv
// Envelope generator: start flag, divider and 15-to-0 decay counter with optional loop.
module apu_envelope #(
  parameter int unsigned VOL_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             quarter_frame_i,
  input  logic             start_set_i,
  input  logic             loop_i,
  input  logic [VOL_W-1:0] v_i,
  output logic [VOL_W-1:0] decay_o
);

  logic             start_q, start_d;
  logic [VOL_W-1:0] div_q, div_d;
  logic [VOL_W-1:0] decay_q, decay_d;

  // A start request arriving with a quarter-frame lands after that frame step.
  always_comb begin
    start_d = start_q;
    div_d   = div_q;
    decay_d = decay_q;
    if (quarter_frame_i) begin
      if (start_q) begin
        start_d = 1'b0;
        div_d   = v_i;
        decay_d = '1;
      end else if (div_q == '0) begin
        div_d = v_i;
        if (decay_q != '0) begin
          decay_d = decay_q - VOL_W'(1);
        end else if (loop_i) begin
          decay_d = '1;
        end
      end else begin
        div_d = div_q - VOL_W'(1);
      end
    end
    if (start_set_i) begin
      start_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      start_q <= 1'b0;
      div_q   <= '0;
      decay_q <= '0;
    end else begin
      start_q <= start_d;
      div_q   <= div_d;
      decay_q <= decay_d;
    end
  end

  assign decay_o = decay_q;

endmodule

// File: rtl/apu_pulse_channel.sv
// NES-style pulse channel: timer, duty sequencer, envelope, sweep with mute, length counter.
module apu_pulse_channel
  import apu_pkg::*;
#(
  parameter int unsigned CHANNEL = 0,
  parameter int unsigned TIMER_W = 11,
  parameter int unsigned VOL_W   = 4,
  parameter int unsigned LEN_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             apu_tick,
  input  logic             quarter_frame,
  input  logic             half_frame,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             chan_en,
  output logic [VOL_W-1:0] vol,
  output logic             len_active
);

  localparam int unsigned TW1  = TIMER_W + 1;
  localparam int unsigned HI_W = TIMER_W - 8;
  // Pulse 1 negates in ones' complement, which subtracts one extra.
  localparam logic [TIMER_W:0] NEG_BIAS = (CHANNEL == 0) ? TW1'(1) : TW1'(0);

  ctrl_reg_t          ctrl_q, ctrl_d;
  sweep_reg_t         sweep_q, sweep_d;
  logic               reload_q, reload_d;
  logic [2:0]         sdiv_q, sdiv_d;
  logic [TIMER_W-1:0] period_q, period_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [2:0]         seq_q, seq_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [VOL_W-1:0]   vol_q, vol_d;
  logic               len_active_q, len_active_d;

  logic               wr_ctrl_c, wr_sweep_c, wr_lo_c, wr_hi_c;
  tmr_hi_reg_t        hi_c;
  logic [TIMER_W:0]   period_ext_c, delta_c, target_c;
  logic               mute_c;
  logic [VOL_W-1:0]   env_decay_c;

  assign wr_ctrl_c  = wr_en && (wr_addr == ADDR_CTRL);
  assign wr_sweep_c = wr_en && (wr_addr == ADDR_SWEEP);
  assign wr_lo_c    = wr_en && (wr_addr == ADDR_TMR_LO);
  assign wr_hi_c    = wr_en && (wr_addr == ADDR_TMR_HI);
  assign hi_c       = tmr_hi_reg_t'(wr_data);

  apu_envelope #(
    .VOL_W(VOL_W)
  ) u_env (
    .clk_i          (clk),
    .reset_i        (reset),
    .quarter_frame_i(quarter_frame),
    .start_set_i    (wr_hi_c),
    .loop_i         (ctrl_q.halt),
    .v_i            (VOL_W'(ctrl_q.v)),
    .decay_o        (env_decay_c)
  );

  // Sweep target is one bit wider so add-mode overflow shows up in the top bit.
  always_comb begin
    period_ext_c = {1'b0, period_q};
    delta_c      = period_ext_c >> sweep_q.shift;
    if (sweep_q.neg) begin
      target_c = period_ext_c - delta_c - NEG_BIAS;
    end else begin
      target_c = period_ext_c + delta_c;
    end
    mute_c = (period_q < TIMER_W'(8)) || (!sweep_q.neg && target_c[TIMER_W]);
  end

  // Frame-driven updates use current state; register writes are applied afterwards and win.
  always_comb begin
    ctrl_d       = ctrl_q;
    sweep_d      = sweep_q;
    reload_d     = reload_q;
    sdiv_d       = sdiv_q;
    period_d     = period_q;
    cnt_d        = cnt_q;
    seq_d        = seq_q;
    len_d        = len_q;
    vol_d        = '0;
    len_active_d = (len_q != '0);

    if (apu_tick) begin
      if (cnt_q == '0) begin
        cnt_d = period_q;
        seq_d = seq_q - 3'd1;
      end else begin
        cnt_d = cnt_q - TIMER_W'(1);
      end
    end

    if (half_frame) begin
      if ((sdiv_q == '0) && sweep_q.en && (sweep_q.shift != '0) && !mute_c) begin
        period_d = target_c[TIMER_W-1:0];
      end
      if ((sdiv_q == '0) || reload_q) begin
        sdiv_d   = sweep_q.period;
        reload_d = 1'b0;
      end else begin
        sdiv_d = sdiv_q - 3'd1;
      end
      if (!ctrl_q.halt && (len_q != '0)) begin
        len_d = len_q - LEN_W'(1);
      end
    end

    if (wr_ctrl_c) begin
      ctrl_d = ctrl_reg_t'(wr_data);
    end
    if (wr_sweep_c) begin
      sweep_d  = sweep_reg_t'(wr_data);
      reload_d = 1'b1;
    end
    if (wr_lo_c) begin
      period_d[7:0] = wr_data;
    end
    if (wr_hi_c) begin
      period_d[TIMER_W-1:8] = HI_W'(hi_c.period_hi);
      seq_d                 = '0;
      if (chan_en) begin
        len_d = LEN_W'(LEN_TABLE[hi_c.len_idx]);
      end
    end
    if (!chan_en) begin
      len_d = '0;
    end

    if (!mute_c && (len_q != '0) && duty_bit(ctrl_q.duty, seq_q)) begin
      vol_d = ctrl_q.cst ? VOL_W'(ctrl_q.v) : env_decay_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q       <= '0;
      sweep_q      <= '0;
      reload_q     <= 1'b0;
      sdiv_q       <= '0;
      period_q     <= '0;
      cnt_q        <= '0;
      seq_q        <= '0;
      len_q        <= '0;
      vol_q        <= '0;
      len_active_q <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      sweep_q      <= sweep_d;
      reload_q     <= reload_d;
      sdiv_q       <= sdiv_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      seq_q        <= seq_d;
      len_q        <= len_d;
      vol_q        <= vol_d;
      len_active_q <= len_active_d;
    end
  end

  assign vol        = vol_q;
  assign len_active = len_active_q;

endmodule
